// File: rtl/vga_plot_arbiter.sv
// Purpose : shares one VGA adapter pixel-write port among NREQ drawing engines, one whole job at a time.
// Latency : start rises 1 cycle after req is seen in IDLE; pixel path is 1-cycle registered.
// Backpres: none; the owner keeps the port until done, and everyone else waits in req.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req/ack             per-engine job request (level) and one-cycle completion pulse
//   start/done          per-engine start (high for the whole job) and done handshake
//   req_x/y/colour/plot packed per-engine pixel writes; engine i owns slice i
//   vga_x/y/colour/plot registered, clipped pixel write towards the adapter
//   grant, busy         one-hot current owner and "not idle" status
//   timeout_err         sticky watchdog flag
//
// Optional feature: define ARB_TIMEOUT_EN to build the RUN-state watchdog
// (TIMEOUT_CYCLES, 16-bit counter). Without it timeout_err is tied low and
// RUN waits indefinitely for done.
module vga_plot_arbiter #(
    parameter int NREQ           = 3,
    parameter int XMAX           = 160,
    parameter int YMAX           = 120,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   start,
    input  logic [NREQ-1:0]   done,
    input  logic [NREQ*8-1:0] req_x,
    input  logic [NREQ*7-1:0] req_y,
    input  logic [NREQ*3-1:0] req_colour,
    input  logic [NREQ-1:0]   req_plot,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // One extra bit so the compare is unsigned over the full x/y range
    // (y = 120..127 and x = 160..255 must be rejected).
    localparam logic [8:0] X_LIM = 9'(XMAX);
    localparam logic [7:0] Y_LIM = 8'(YMAX);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RELEASE
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   last;
    logic [IDXW-1:0]   gidx;

    logic [IDXW-1:0]   win;
    logic [NREQ-1:0]   win_onehot;

    logic [7:0]        sel_x;
    logic [6:0]        sel_y;
    logic [2:0]        sel_colour;
    logic              sel_plot;
    logic              sel_done;
    logic              clip_ok;
    logic              own_port;

    // Round-robin pick: the lowest requester above last wins; if none is
    // above last, the lowest requester at or below last wins. The second
    // loop overwrites the first, which gives the "above last" group priority.
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IDXW'(i) <= last)) begin
                win = IDXW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IDXW'(i) > last)) begin
                win = IDXW'(i);
            end
        end
    end

    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    // Granted-slice mux for the pixel path and the done handshake.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_done   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDXW'(i)) begin
                sel_x      = req_x[i*8 +: 8];
                sel_y      = req_y[i*7 +: 7];
                sel_colour = req_colour[i*3 +: 3];
                sel_plot   = req_plot[i];
                sel_done   = done[i];
            end
        end
    end

    assign clip_ok  = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    assign own_port = (state == START) || (state == RUN);

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= IDXW'(NREQ - 1);
            gidx       <= '0;
            grant      <= '0;
            start      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack <= '0;

            case (state)
                IDLE: begin
                    if (|req) begin
                        gidx  <= win;
                        last  <= win;
                        grant <= win_onehot;
                        start <= win_onehot;
                        busy  <= 1'b1;
                        state <= START;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end

                START: begin
                    state <= RUN;
                end

                RUN: begin
                    if (sel_done) begin
                        start <= '0;
                        ack   <= grant;
                        state <= RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_cnt == TO_LAST) begin
                        // Engine hung: reclaim the port, still ack so the
                        // requester's own sequencing can move on.
                        start       <= '0;
                        ack         <= grant;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end

                RELEASE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Only the owner's pixels reach the adapter; coordinates hold
            // their last value outside a job.
            if (own_port) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
                vga_plot   <= sel_plot && clip_ok;
            end else begin
                vga_plot   <= 1'b0;
            end
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule
